// File: rtl/event_monitor.sv
// event_monitor: multi-channel edge detector with per-channel saturating
// counters, sticky pending/overflow flags, ack/clear and an OR-combined irq.
// Revision: 1.0
`default_nettype none

module event_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int SEL_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     sig_in,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [NUM_CH-1:0]     irq_en,
  input  logic                  ack_valid,
  input  logic [SEL_W-1:0]      ack_sel,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [NUM_CH-1:0]     pending,
  output logic                  irq,
  output logic [CNT_W-1:0]      rd_cnt,
  output logic [NUM_CH-1:0]     overflow
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [NUM_CH-1:0] r_prev;
  logic              r_primed;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_overflow;
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic              r_irq;
  logic [CNT_W-1:0]  r_rd_cnt;

  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_ev;
  logic [NUM_CH-1:0] w_ack_hit;
  logic [NUM_CH-1:0] w_pend_n;
  logic [NUM_CH-1:0] w_ovf_n;
  logic [CNT_W-1:0]  w_cnt_n [NUM_CH];
  logic [CNT_W-1:0]  w_rd_n;
  logic              w_irq_n;

  assign w_rise = sig_in & ~r_prev;
  assign w_fall = ~sig_in & r_prev;

  always_comb begin
    w_ev      = '0;
    w_ack_hit = '0;
    w_pend_n  = r_pending;
    w_ovf_n   = r_overflow;
    w_cnt_n   = r_cnt;
    w_rd_n    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      unique case (mode[2*i +: 2])
        2'd1:    w_ev[i] = w_rise[i];
        2'd2:    w_ev[i] = w_fall[i];
        2'd3:    w_ev[i] = w_rise[i] | w_fall[i];
        default: w_ev[i] = 1'b0;
      endcase
      // Until primed, prev holds reset zeros, not real history.
      w_ev[i]      = w_ev[i] & r_primed;
      w_ack_hit[i] = ack_valid && (ack_sel == SEL_W'(i));

      if (w_ev[i]) begin
        w_pend_n[i] = 1'b1;
        if (w_ack_hit[i]) begin
          // Event beats a simultaneous ack: counter restarts at one.
          w_cnt_n[i] = CNT_W'(1);
          w_ovf_n[i] = 1'b0;
        end else if (r_cnt[i] == C_CNT_MAX) begin
          w_ovf_n[i] = 1'b1;
        end else begin
          w_cnt_n[i] = r_cnt[i] + CNT_W'(1);
        end
      end else if (w_ack_hit[i]) begin
        w_pend_n[i] = 1'b0;
        w_ovf_n[i]  = 1'b0;
        w_cnt_n[i]  = '0;
      end

      if (rd_sel == SEL_W'(i)) begin
        w_rd_n = w_cnt_n[i];
      end
    end
    w_irq_n = |(w_pend_n & irq_en);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev     <= '0;
      r_primed   <= 1'b0;
      r_pending  <= '0;
      r_overflow <= '0;
      r_irq      <= 1'b0;
      r_rd_cnt   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_prev     <= sig_in;
      r_primed   <= 1'b1;
      r_pending  <= w_pend_n;
      r_overflow <= w_ovf_n;
      r_irq      <= w_irq_n;
      r_rd_cnt   <= w_rd_n;
      r_cnt      <= w_cnt_n;
    end
  end

  assign pending  = r_pending;
  assign overflow = r_overflow;
  assign irq      = r_irq;
  assign rd_cnt   = r_rd_cnt;

endmodule

`default_nettype wire

// File: tb/tb_event_monitor.sv
// tb_event_monitor: scoreboard bench for event_monitor (3 channels, so
// channel index 3 exercises the out-of-range ack/readback paths).
`default_nettype none

module tb_event_monitor;

  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int SW  = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    sig_in;
  logic [2*NCH-1:0]  mode;
  logic [NCH-1:0]    irq_en;
  logic              ack_valid;
  logic [SW-1:0]     ack_sel;
  logic [SW-1:0]     rd_sel;
  logic [NCH-1:0]    pending;
  logic              irq;
  logic [CW-1:0]     rd_cnt;
  logic [NCH-1:0]    overflow;

  event_monitor #(.NUM_CH(NCH), .CNT_W(CW), .SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .mode(mode), .irq_en(irq_en),
    .ack_valid(ack_valid), .ack_sel(ack_sel), .rd_sel(rd_sel),
    .pending(pending), .irq(irq), .rd_cnt(rd_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] pend;
    logic [NCH-1:0] ovf;
    logic           irq;
    logic [CW-1:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: plain integers and bits.
  int m_cnt  [NCH];
  bit m_pend [NCH];
  bit m_ovf  [NCH];
  bit m_prev [NCH];
  bit m_primed;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(output exp_t e);
    bit r, f, ev;
    int md;
    int any;
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0; m_pend[i] = 0; m_ovf[i] = 0; m_prev[i] = 0;
      end
      m_primed = 0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r  = sig_in[i] && !m_prev[i];
        f  = !sig_in[i] && m_prev[i];
        md = int'(mode[2*i +: 2]);
        ev = m_primed && ((md == 1 && r) || (md == 2 && f) || (md == 3 && (r || f)));
        if (ack_valid && int'(ack_sel) == i) begin
          m_cnt[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
        end
        if (ev) begin
          m_pend[i] = 1;
          if (m_cnt[i] == CMAX) m_ovf[i] = 1;
          else m_cnt[i] = m_cnt[i] + 1;
        end
        m_prev[i] = sig_in[i];
      end
      m_primed = 1;
    end
    any = 0;
    for (int i = 0; i < NCH; i++) begin
      e.pend[i] = m_pend[i];
      e.ovf[i]  = m_ovf[i];
      if (m_pend[i] && irq_en[i]) any = 1;
    end
    e.irq = (any != 0);
    e.rd  = (int'(rd_sel) < NCH) ? CW'(m_cnt[int'(rd_sel)]) : '0;
  endtask

  // Compute the expected post-edge state, then hand it to the monitor.
  task automatic tick();
    exp_t e;
    model_step(e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    ack_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic ack(input int ch);
    ack_valid = 1'b1;
    ack_sel   = SW'(ch);
    tick();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pending",  int'(pending),  int'(e.pend));
      check("overflow", int'(overflow), int'(e.ovf));
      check("irq",      int'(irq),      int'(e.irq));
      check("rd_cnt",   int'(rd_cnt),   int'(e.rd));
    end
  end

  initial begin
    reset = 1'b0; sig_in = '1; mode = '1; irq_en = '1;
    ack_valid = 1'b0; ack_sel = '0; rd_sel = '0;
    ticks(3);

    // High inputs at reset release must not count as edges.
    reset = 1'b1;
    ticks(3);

    // Posedge on channel 0 only.
    mode = 6'b00_00_01; irq_en = 3'b001; rd_sel = 2'd0;
    sig_in = 3'b000; ticks(3);
    sig_in = 3'b001; ticks(2);
    sig_in = 3'b000; ticks(2);
    ack(0);

    // Any-edge on channel 2 until saturation and overflow.
    mode = 6'b11_00_00; irq_en = 3'b100; rd_sel = 2'd2;
    for (int k = 0; k < 300; k++) begin
      sig_in[2] = ~sig_in[2];
      tick();
    end
    ticks(2);
    ack(2);

    // Ack colliding with a negedge on channel 1 after five counted events.
    mode = 6'b00_10_00; irq_en = 3'b010; rd_sel = 2'd1;
    sig_in = 3'b010; ticks(2);
    for (int k = 0; k < 5; k++) begin
      sig_in[1] = 1'b0; tick();
      sig_in[1] = 1'b1; tick();
    end
    sig_in[1] = 1'b0; ack_valid = 1'b1; ack_sel = 2'd1;
    tick();
    ticks(2);

    // Masking: events on 0 and 2, only 2 enabled; out-of-range ack/readback.
    mode = 6'b01_00_01; irq_en = 3'b100; rd_sel = 2'd0;
    ack(0); ack(1); ack(2);
    sig_in = 3'b000; tick();
    sig_in = 3'b101; ticks(2);
    ack(2);
    ticks(1);
    rd_sel = 2'd3;
    ack(3);
    ticks(2);

    // Mid-run reset during activity.
    mode = '1; irq_en = '1;
    sig_in = 3'b010; tick();
    sig_in = 3'b101; reset = 1'b0; tick();
    reset = 1'b1; sig_in = 3'b010; tick();
    sig_in = 3'b101; ticks(2);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      sig_in = NCH'($urandom);
      if ($urandom_range(0, 19) == 0) mode = (2*NCH)'($urandom);
      if ($urandom_range(0, 29) == 0) irq_en = NCH'($urandom);
      ack_valid = ($urandom_range(0, 7) == 0);
      ack_sel   = SW'($urandom);
      rd_sel    = SW'($urandom);
      reset     = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset = 1'b1;
    ticks(2);

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
